bus_scheduler: RTL and testbench

- Shares the external bus arbiter between three requesters: instruction fetch, data read and data write.
- Selects one requester and issues its opcode to the arbiter: FETCH=8, DRD=9 or DWR=10.
- Holds that opcode until the arbiter's done, then acknowledges the winner.
- Provides fixed priority with fetch anti-starvation, plus a watchdog that recovers from an arbiter that never answers.

---
 rtl/bus_scheduler.sv | 173 +++++++++++++++++
 tb/tb_bus_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_scheduler.sv
// bus_scheduler
//   Shares the external bus arbiter between three requesters (instruction
//   fetch, data read, data write). One transaction is in flight at a time:
//   the winner's opcode is issued, held until the arbiter reports done (or
//   the watchdog expires), and then the winner is acknowledged.
//
// Ports
//   clk          system clock, all state on the rising edge
//   reset        asynchronous, active-low reset
//   fetch_req    fetch request (level, held until fetch_ack)
//   rd_req       data read request (level, held until rd_ack)
//   wr_req       data write request (level, held until wr_ack)
//   fetch_ack    one-cycle completion pulse to the fetch requester
//   rd_ack       one-cycle completion pulse to the read requester
//   wr_ack       one-cycle completion pulse to the write requester
//   bus_request  request strobe to the arbiter (restarts its step counter)
//   bus_opcode   FETCH=8 / DRD=9 / DWR=10 while a transaction is open, else 0
//   bus_done     arbiter done (combinational on the arbiter side)
//   busy         high while issuing or waiting on the arbiter
//   timeout_err  one-cycle pulse when the watchdog aborts a transaction
//
// Every output is a decode of registered state, so no input reaches an
// output combinationally.
module bus_scheduler #(
    parameter int TIMEOUT = 64,
    parameter int STARVE  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fetch_req,
    input  logic       rd_req,
    input  logic       wr_req,
    output logic       fetch_ack,
    output logic       rd_ack,
    output logic       wr_ack,
    output logic       bus_request,
    output logic [3:0] bus_opcode,
    input  logic       bus_done,
    output logic       busy,
    output logic       timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT);
    localparam int SC_W = $clog2(STARVE + 1);

    localparam logic [3:0] OP_FETCH = 4'd8;
    localparam logic [3:0] OP_DRD   = 4'd9;
    localparam logic [3:0] OP_DWR   = 4'd10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT     = 2'd2,
        COMPLETE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_FETCH = 2'd1,
        GNT_RD    = 2'd2,
        GNT_WR    = 2'd3
    } grant_t;

    state_t           state_q, state_d;
    grant_t           grant_q, grant_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             abort_q, abort_d;
    logic [SC_W-1:0]  starve_cnt, starve_d;

    logic             starve_full;
    assign starve_full = (starve_cnt == SC_W'(STARVE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            grant_q    <= GNT_NONE;
            wd_q       <= '0;
            abort_q    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            wd_q       <= wd_d;
            abort_q    <= abort_d;
            starve_cnt <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        wd_d     = wd_q;
        abort_d  = abort_q;
        starve_d = starve_cnt;

        unique case (state_q)
            IDLE: begin
                // A fetch that is not pending cannot be starving.
                if (!fetch_req) begin
                    starve_d = '0;
                end

                if (fetch_req && starve_full) begin
                    // Promoted fetch overrides the fixed wr > rd > fetch order.
                    grant_d  = GNT_FETCH;
                    starve_d = '0;
                    state_d  = ISSUE;
                end else if (wr_req || rd_req) begin
                    grant_d = wr_req ? GNT_WR : GNT_RD;
                    if (fetch_req && !starve_full) begin
                        starve_d = starve_cnt + 1'b1;
                    end
                    state_d = ISSUE;
                end else if (fetch_req) begin
                    grant_d  = GNT_FETCH;
                    starve_d = '0;
                    state_d  = ISSUE;
                end

                if (state_d == ISSUE) begin
                    abort_d = 1'b0;
                end
            end

            ISSUE: begin
                // bus_done may still reflect the previous operation's step
                // count here, so it is deliberately not looked at.
                wd_d    = '0;
                state_d = WAIT;
            end

            WAIT: begin
                if (bus_done) begin
                    state_d = COMPLETE;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    abort_d = 1'b1;
                    state_d = COMPLETE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end

            COMPLETE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from registered state only.
    assign bus_request = (state_q == ISSUE);
    assign busy        = (state_q == ISSUE) || (state_q == WAIT);
    assign fetch_ack   = (state_q == COMPLETE) && (grant_q == GNT_FETCH);
    assign rd_ack      = (state_q == COMPLETE) && (grant_q == GNT_RD);
    assign wr_ack      = (state_q == COMPLETE) && (grant_q == GNT_WR);
    assign timeout_err = (state_q == COMPLETE) && abort_q;

    always_comb begin
        bus_opcode = 4'd0;
        if (busy) begin
            unique case (grant_q)
                GNT_FETCH: bus_opcode = OP_FETCH;
                GNT_RD:    bus_opcode = OP_DRD;
                GNT_WR:    bus_opcode = OP_DWR;
                default:   bus_opcode = 4'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_scheduler.sv
// tb_bus_scheduler
//   Directed bench for bus_scheduler with a small arbiter model: the arbiter
//   step counter restarts on bus_request and signals done at step 2 (third
//   WAIT cycle). Modes let the bench silence the arbiter or inject a stale
//   done during the ISSUE cycle.
module tb_bus_scheduler;

    localparam int TIMEOUT = 64;
    localparam int STARVE  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       fetch_req, rd_req, wr_req;
    logic       fetch_ack, rd_ack, wr_ack;
    logic       bus_request;
    logic [3:0] bus_opcode;
    logic       bus_done;
    logic       busy;
    logic       timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Arbiter model controls
    bit       arb_en    = 1'b1;
    bit       stale_inj = 1'b0;
    int       step      = 7;

    bus_scheduler #(.TIMEOUT(TIMEOUT), .STARVE(STARVE)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .fetch_ack   (fetch_ack),
        .rd_ack      (rd_ack),
        .wr_ack      (wr_ack),
        .bus_request (bus_request),
        .bus_opcode  (bus_opcode),
        .bus_done    (bus_done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus_request) step <= 0;
        else if (step < 7) step <= step + 1;
    end

    assign bus_done = (arb_en && bus_opcode != 4'd0 && step == 2)
                    || (stale_inj && bus_request);

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for the next ISSUE, check its opcode, then wait for the ack and
    // check which requester got it, the ISSUE->ack distance and the error flag.
    task automatic serve(input string tag, input int exp_op,
                         input logic [2:0] exp_ack, input int exp_lat,
                         input bit drop);
        bit seen;
        int lat;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus_request) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_issue"}, int'(seen), 1);
        check({tag, "_op"}, int'(bus_opcode), exp_op);
        lat = 0;
        while (!(fetch_ack || rd_ack || wr_ack) && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, "_ack"}, int'({fetch_ack, rd_ack, wr_ack}), int'(exp_ack));
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_op0"}, int'(bus_opcode), 0);
        check({tag, "_terr"}, int'(timeout_err), 0);
        if (drop) begin
            if (exp_ack[2]) fetch_req = 1'b0;
            if (exp_ack[1]) rd_req    = 1'b0;
            if (exp_ack[0]) wr_req    = 1'b0;
        end
    endtask

    initial begin
        int wc;
        bit bad;

        reset = 1'b0;
        fetch_req = 1'b0;
        rd_req = 1'b0;
        wr_req = 1'b0;
        tick();
        tick();
        check("rst_outs", int'({fetch_ack, rd_ack, wr_ack, bus_request, busy, timeout_err}), 0);
        check("rst_op", int'(bus_opcode), 0);
        check("rst_starve", int'(dut.starve_cnt), 0);
        reset = 1'b1;
        tick();

        // Single read: ISSUE one cycle, opcode held through WAIT, ack 5 cycles
        // after the IDLE sample.
        rd_req = 1'b1;
        tick();
        check("rd_req_strobe", int'(bus_request), 1);
        check("rd_issue_op", int'(bus_opcode), 9);
        tick();
        check("rd_wait_strobe", int'(bus_request), 0);
        check("rd_wait_op", int'(bus_opcode), 9);
        tick();
        tick();
        check("rd_w3_op", int'(bus_opcode), 9);
        check("rd_w3_noack", int'(rd_ack), 0);
        tick();
        check("rd_ack", int'({fetch_ack, rd_ack, wr_ack}), 3'b010);
        check("rd_cmp_op", int'(bus_opcode), 0);
        rd_req = 1'b0;
        tick();
        check("rd_idle", int'({rd_ack, busy}), 0);
        tick();

        // All three together: wr, rd, fetch.
        fetch_req = 1'b1;
        rd_req = 1'b1;
        wr_req = 1'b1;
        tick();
        serve("pri_wr", 10, 3'b001, 4, 1'b1);
        serve("pri_rd", 9, 3'b010, 4, 1'b1);
        serve("pri_fe", 8, 3'b100, 4, 1'b1);
        tick();
        tick();

        // Anti-starvation: wr/rd held, fetch held.
        fetch_req = 1'b1;
        rd_req = 1'b1;
        wr_req = 1'b1;
        for (int k = 0; k < STARVE; k++) serve("stv_wr", 10, 3'b001, 4, 1'b0);
        check("stv_full", int'(dut.starve_cnt), STARVE);
        serve("stv_fe", 8, 3'b100, 4, 1'b1);
        check("stv_clear", int'(dut.starve_cnt), 0);
        serve("stv_wr_after", 10, 3'b001, 4, 1'b1);
        serve("stv_rd_after", 9, 3'b010, 4, 1'b1);
        tick();
        tick();

        // Watchdog: arbiter never answers.
        arb_en = 1'b0;
        rd_req = 1'b1;
        for (int i = 0; i < 20 && !bus_request; i++) tick();
        check("to_issue", int'(bus_request), 1);
        tick();
        wc = 0;
        while (busy && wc < 200) begin
            wc++;
            tick();
        end
        check("to_wait_len", wc, TIMEOUT);
        check("to_ack", int'({fetch_ack, rd_ack, wr_ack}), 3'b010);
        check("to_err", int'(timeout_err), 1);
        rd_req = 1'b0;
        arb_en = 1'b1;
        tick();
        check("to_idle", int'({busy, timeout_err, rd_ack}), 0);
        wr_req = 1'b1;
        serve("to_next", 10, 3'b001, 4, 1'b1);
        tick();
        tick();

        // Asynchronous reset mid-WAIT of a write.
        wr_req = 1'b1;
        for (int i = 0; i < 20 && !bus_request; i++) tick();
        tick();
        tick();
        check("ar_in_wait", int'(busy), 1);
        #2 reset = 1'b0;
        #1;
        check("ar_outs", int'({fetch_ack, rd_ack, wr_ack, bus_request, busy, timeout_err}), 0);
        check("ar_op", int'(bus_opcode), 0);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wr_ack || busy) bad = 1'b1;
        end
        check("ar_no_ack", int'(bad), 0);
        reset = 1'b1;
        serve("ar_reissue", 10, 3'b001, 4, 1'b1);
        tick();
        tick();

        // Stale done during ISSUE must be ignored.
        stale_inj = 1'b1;
        rd_req = 1'b1;
        for (int i = 0; i < 20 && !bus_request; i++) tick();
        check("stale_done_seen", int'(bus_done), 1);
        tick();
        stale_inj = 1'b0;
        check("stale_still_wait", int'({busy, rd_ack}), 2'b10);
        wc = 1;
        while (!rd_ack && wc < 200) begin
            tick();
            wc++;
        end
        check("stale_lat", wc, 4);
        check("stale_ack", int'({fetch_ack, rd_ack, wr_ack}), 3'b010);
        rd_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
